dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (CPU = port 0, DMA = port 1) arbiter in front of a single data memory.
// Round-robin by default; define DMEM_ARB_PRIO_EN for fixed priority to port 0.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [2:0]  memOp0,
  input  logic [2:0]  memOp1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] memAddr,
  output logic [31:0] memDin,
  output logic [2:0]  memOp,
  output logic        memWe,
  input  logic [31:0] memDout,
  output logic [1:0]  dbgState
);

  // Handshake: a port raises req with we/addr/wdata/memOp stable and holds them
  // until it sees gnt in the same cycle; the request is captured on that edge and
  // the port later gets exactly one done pulse (with err/rdata) for it.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  state_t      state, stateNxt;
  logic        armed;
  logic        owner;
  logic        latWe;
  logic [31:0] latAddr, latData;
  logic [2:0]  latOp;

  logic        selPort, grant, selWe, selMis;
  logic [31:0] selAddr, selData;
  logic [2:0]  selOp;
  logic        doneAny, errAny;
  logic [31:0] rdAny;

`ifdef DMEM_ARB_PRIO_EN
  assign selPort = ~req0;
`else
  logic lastGrant;

  // On a tie the port not served last wins; single requests win outright.
  assign selPort = (req0 && req1) ? ~lastGrant : req1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      lastGrant <= 1'b1;
    else if (grant) lastGrant <= selPort;
  end
`endif

  // armed holds off grants until the first rising edge after reset release.
  assign grant   = armed && (state == IDLE) && (req0 || req1);
  assign selWe   = selPort ? we1    : we0;
  assign selAddr = selPort ? addr1  : addr0;
  assign selData = selPort ? wdata1 : wdata0;
  assign selOp   = selPort ? memOp1 : memOp0;
  assign selMis  = (((selOp == 3'd1) || (selOp == 3'd5)) && selAddr[0]) ||
                   ((selOp == 3'd2) && (selAddr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) armed <= 1'b0;
    else       armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner   <= 1'b0;
      latWe   <= 1'b0;
      latAddr <= '0;
      latData <= '0;
      latOp   <= '0;
    end else if (grant) begin
      owner   <= selPort;
      latWe   <= selWe;
      latAddr <= selAddr;
      latData <= selData;
      latOp   <= selOp;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (grant) stateNxt = selMis ? ERR : ISSUE;
      ISSUE:   stateNxt = latWe ? IDLE : WAIT;
      WAIT:    stateNxt = IDLE;
      ERR:     stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    memWe   = 1'b0;
    doneAny = 1'b0;
    errAny  = 1'b0;
    rdAny   = '0;
    if (grant) begin
      gnt0 = ~selPort;
      gnt1 = selPort;
    end
    case (state)
      ISSUE: begin
        memWe   = latWe;
        doneAny = latWe;
      end
      WAIT: begin
        doneAny = 1'b1;
        rdAny   = memDout;
      end
      ERR: begin
        doneAny = 1'b1;
        errAny  = 1'b1;
      end
      default: ;
    endcase
    done0  = doneAny & ~owner;
    done1  = doneAny & owner;
    err0   = errAny & ~owner;
    err1   = errAny & owner;
    rdata0 = owner ? 32'd0 : rdAny;
    rdata1 = owner ? rdAny : 32'd0;
  end

  assign memAddr  = latAddr;
  assign memDin   = latData;
  assign memOp    = latOp;
  assign dbgState = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model (grant choice, access length, per-cycle expected outputs).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  memOp0, memOp1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1, memAddr, memDin, memDout;
  logic [2:0]  memOp;
  logic        memWe;
  logic [1:0]  dbgState;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .memOp0(memOp0), .memOp1(memOp1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
    .memAddr(memAddr), .memDin(memDin), .memOp(memOp), .memWe(memWe),
    .memDout(memDout), .dbgState(dbgState)
  );

  int ntests = 0;
  int nfail  = 0;

  // Reference model: one outstanding transaction of known length.
  bit          m_busy, m_owner, m_we, m_mis, m_last, m_arm;
  int          m_len, m_k;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_op;
  bit          e_g0, e_g1;
  int          gnt_log[$];
  logic [2:0]  ops[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  function automatic bit misaligned(input logic [2:0] op, input logic [31:0] a);
    return (((op == 3'd1) || (op == 3'd5)) && a[0]) || ((op == 3'd2) && (a[1:0] != 2'b00));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit          last_cyc;
    logic [31:0] r;
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!m_busy && m_arm) begin
      if (req0 && req1) begin
`ifdef DMEM_ARB_PRIO_EN
        e_g0 = 1'b1;
`else
        if (m_last) e_g0 = 1'b1;
        else        e_g1 = 1'b1;
`endif
      end else begin
        e_g0 = req0;
        e_g1 = req1;
      end
    end
    last_cyc = m_busy && (m_k == m_len);
    r = (last_cyc && !m_we && !m_mis) ? memDout : 32'd0;
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("memWe", memWe, m_busy && (m_k == 1) && m_we && !m_mis);
    chk("done0", done0, last_cyc && !m_owner);
    chk("done1", done1, last_cyc && m_owner);
    chk("err0", err0, last_cyc && m_mis && !m_owner);
    chk("err1", err1, last_cyc && m_mis && m_owner);
    chk("rdata0", rdata0, m_owner ? 32'd0 : r);
    chk("rdata1", rdata1, m_owner ? r : 32'd0);
    if (m_busy && (m_k == 1) && !m_mis) begin
      chk("memAddr", memAddr, m_addr);
      chk("memOp", memOp, m_op);
      chk("memDin", memDin, m_wdata);
    end
    if (gnt0) gnt_log.push_back(0);
    if (gnt1) gnt_log.push_back(1);
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    if (m_busy) begin
      if (m_k == m_len) m_busy = 1'b0;
      else              m_k++;
    end else if (e_g0 || e_g1) begin
      m_owner = e_g1;
      m_we    = e_g1 ? we1    : we0;
      m_addr  = e_g1 ? addr1  : addr0;
      m_wdata = e_g1 ? wdata1 : wdata0;
      m_op    = e_g1 ? memOp1 : memOp0;
      m_mis   = misaligned(m_op, m_addr);
      m_len   = m_mis ? 1 : (m_we ? 1 : 2);
      m_k     = 1;
      m_busy  = 1'b1;
      m_last  = e_g1;
    end
    m_arm = 1'b1;
    #1;
    if (e_g0) req0 = 1'b0;
    if (e_g1) req1 = 1'b0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      we0 = w; memOp0 = op; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      we1 = w; memOp1 = op; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
  endtask

  task automatic rand_req(input int p);
    set_req(p, 1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)], $urandom, $urandom);
  endtask

  // Called just after a rising edge; leaves reset released just after a later edge.
  task automatic apply_reset();
    rstn   = 1'b0;
    m_busy = 1'b0;
    m_last = 1'b1;
    m_arm  = 1'b0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_err0", err0, 0);
    chk("rst_err1", err1, 0);
    chk("rst_memWe", memWe, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memDin", memDin, 0);
    chk("rst_memOp", memOp, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy || req0 || req1) && n < 50) begin
      step();
      n++;
    end
    chk("drain_bound", n < 50, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_seq[4];
    rstn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    memOp0 = '0; memOp1 = '0; memDout = '0;

    // Both ports requesting through reset: no grant during reset or before the first edge.
    set_req(0, 1'b1, 3'd2, 32'h10, 32'h1111_0000);
    set_req(1, 1'b1, 3'd2, 32'h20, 32'h2222_0000);
    @(posedge clk);
    #1;
    apply_reset();

    // Sustained contention for four transactions.
`ifdef DMEM_ARB_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    gnt_log.delete();
    n = 0;
    while (gnt_log.size() < 4 && n < 40) begin
      step();
      n++;
      if (!req0) set_req(0, 1'b1, 3'd2, 32'h10 + 32'(n * 4), $urandom);
      if (!req1) set_req(1, 1'b1, 3'd2, 32'h20 + 32'(n * 4), $urandom);
    end
    chk("contend_count", gnt_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("contend_order", gnt_log[i], exp_seq[i]);
    drain();

    // Port 0 aligned word store.
    set_req(0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    drain();
    // Port 1 unsigned byte load at an odd address.
    memDout = 32'h0000AB00;
    set_req(1, 1'b0, 3'd4, 32'h101, 32'h0);
    drain();
    // Port 0 misaligned word load.
    set_req(0, 1'b0, 3'd2, 32'h102, 32'h0);
    drain();

    // Reset while a load sits in WAIT, then a normal access afterwards.
    memDout = 32'h5A5A_1234;
    set_req(0, 1'b0, 3'd2, 32'h200, 32'h0);
    step();
    step();
    apply_reset();
    set_req(1, 1'b0, 3'd5, 32'h302, 32'h0);
    drain();

    // Random traffic.
    repeat (1500) begin
      if (!req0 && $urandom_range(0, 2) == 0) rand_req(0);
      if (!req1 && $urandom_range(0, 2) == 0) rand_req(1);
      memDout = $urandom;
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
